// File: rtl/bt_loader_pkg.sv
// Shared definitions for the branch table loader.
//   bt_state_t : loader FSM states
//   BYTE_W     : width of the incoming byte stream
package bt_loader_pkg;

  typedef enum logic [2:0] {IDLE, HDR, LO, HI, DONE} bt_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/branch_table_regfile.sv
// Branch target table storage: 2**B entries of D bits with a single write
// port. The whole array is presented as a flat vector so the fetch-stage
// lookup can index it combinationally.
//   clk, rst_n : clock and asynchronous active-low reset (clears all entries)
//   we         : write enable
//   waddr      : entry index to write
//   wdata      : entry value
//   entries    : flat view, entry i at entries[i*D +: D]
module branch_table_regfile #(
  parameter int D = 12,
  parameter int B = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [B-1:0]          waddr,
  input  logic [D-1:0]          wdata,
  output logic [(2**B)*D-1:0]   entries
);

  localparam int DEPTH = 2**B;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [D-1:0] entry_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (we && (waddr == B'(gi))) begin
          entry_reg <= wdata;
        end
      end

      assign entries[gi*D +: D] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/branch_table_loader.sv
// Loads the branch target table from a byte stream.
// Stream after start: header byte (N-1), then N (low, high) byte pairs.
// Entries are committed only when their high byte arrives, so the lookup
// never sees a half-assembled entry.
//   clk, rst_n   : clock and asynchronous active-low reset
//   start        : begin a load session (honoured only in IDLE)
//   in_valid     : in_data carries a byte
//   in_data      : stream byte
//   in_ready     : a byte is accepted this cycle when in_valid is high
//   branch_table : committed table, entry i at branch_table[i*D +: D]
//   busy         : a load session is in progress
//   done         : one-cycle pulse when a session completes
//   table_valid  : table holds a completed load and no load is running
module branch_table_loader
  import bt_loader_pkg::*;
#(
  parameter int D = 12,
  parameter int B = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [BYTE_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [(2**B)*D-1:0]   branch_table,
  output logic                  busy,
  output logic                  done,
  output logic                  table_valid
);

  bt_state_t          state_reg;
  logic [B-1:0]       idx_reg;
  logic [B-1:0]       last_idx_reg;
  logic [BYTE_W-1:0]  lo_stage_reg;
  logic               table_valid_reg;

  logic               wr_en;
  logic [D-1:0]       wr_data;

  // Handshake and status flags depend on the registered state only, so
  // in_ready never combinationally follows in_valid.
  assign in_ready    = (state_reg == HDR) || (state_reg == LO) || (state_reg == HI);
  assign busy        = in_ready;
  assign done        = (state_reg == DONE);
  assign table_valid = table_valid_reg;

  // The high byte carries entry[D-1:8]; its remaining upper bits are dropped.
  assign wr_en   = (state_reg == HI) && in_valid;
  assign wr_data = {in_data[D-9:0], lo_stage_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      last_idx_reg    <= '0;
      lo_stage_reg    <= '0;
      table_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg       <= HDR;
            table_valid_reg <= 1'b0;
          end
        end
        HDR: begin
          if (in_valid) begin
            last_idx_reg <= in_data[B-1:0];
            idx_reg      <= '0;
            state_reg    <= LO;
          end
        end
        LO: begin
          if (in_valid) begin
            lo_stage_reg <= in_data;
            state_reg    <= HI;
          end
        end
        HI: begin
          if (in_valid) begin
            // Stop on the last index rather than wrapping, so a full
            // 2**B load never revisits entry 0.
            if (idx_reg == last_idx_reg) begin
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= LO;
            end
          end
        end
        DONE: begin
          table_valid_reg <= 1'b1;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  branch_table_regfile #(
    .D (D),
    .B (B)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .waddr   (idx_reg),
    .wdata   (wr_data),
    .entries (branch_table)
  );

endmodule
